// File: rtl/uart_arb_pkg.sv
// rtl/uart_arb_pkg.sv - shared FSM states and constants for the UART TX word arbiter
package uart_arb_pkg;

  typedef enum logic [3:0] {
    IDLE,
    START,
    SETTLE,
    SEND,
    WAIT_TX,
    NEXT,
    FLUSH,
    HDR,
    HDR_WAIT
  } state_t;

  localparam logic [3:0] BYTES_PER_WORD = 4'd8;
  localparam logic [1:0] SETTLE_START   = 2'd2;
  localparam logic [1:0] SETTLE_NEXT    = 2'd1;
  localparam logic [3:0] HDR_TAG        = 4'hA;

endpackage

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - combinational round-robin pick: lowest requester at or after ptr, cyclically
module rr_arbiter #(
  parameter int N  = 4,
  parameter int IW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  grant,
  output logic [IW-1:0] idx,
  output logic          any
);

  logic hit_hi;

  // First look at or above ptr, then wrap to the low indices.
  always_comb begin
    idx    = '0;
    hit_hi = 1'b0;
    for (int i = N - 1; i >= 0; i--) begin
      if (req[i] && (IW'(i) >= ptr)) begin
        idx    = IW'(i);
        hit_hi = 1'b1;
      end
    end
    if (!hit_hi) begin
      for (int i = N - 1; i >= 0; i--) begin
        if (req[i]) idx = IW'(i);
      end
    end
    any   = |req;
    grant = '0;
    if (any) grant[idx] = 1'b1;
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// rtl/uart_tx_arbiter.sv - shares the word-to-byte serializer among N_REQ producers and paces it from UART TX
// UART_ARB_HEADER_EN prefixes each word with a {HDR_TAG, grant_id} header byte.
module uart_tx_arbiter
  import uart_arb_pkg::*;
#(
  parameter int N_REQ = 4,
  parameter int DW    = 64,
  localparam int IW   = $clog2(N_REQ)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [N_REQ-1:0]    req_valid,
  input  logic [N_REQ*DW-1:0] req_data,
  output logic [N_REQ-1:0]    req_ack,
  output logic                ser_start,
  output logic [DW-1:0]       ser_dato,
  output logic                ser_next,
  input  logic [7:0]          ser_byte,
  input  logic                ser_flat,
  output logic                tx_start,
  output logic [7:0]          tx_byte,
  input  logic                tx_done,
  output logic                busy,
  output logic [IW-1:0]       grant_id,
  output logic                err
);

  state_t           state, state_nxt;
  logic [IW-1:0]    ptr, ptr_nxt, grant_id_nxt;
  logic [3:0]       cnt, cnt_nxt;
  logic [1:0]       settle, settle_nxt;
  logic [DW-1:0]    ser_dato_nxt;
  logic [7:0]       tx_byte_nxt;
  logic [N_REQ-1:0] req_ack_nxt, arb_grant;
  logic [IW-1:0]    arb_idx;
  logic             arb_any;
  logic             ser_start_nxt, ser_next_nxt, tx_start_nxt, err_nxt;
  logic             tx_done_ok;

  rr_arbiter #(.N(N_REQ), .IW(IW)) u_rr (
    .req   (req_valid),
    .ptr   (ptr),
    .grant (arb_grant),
    .idx   (arb_idx),
    .any   (arb_any)
  );

  // A completion coinciding with our own start pulse cannot belong to this byte.
  assign tx_done_ok = tx_done & ~tx_start;
  assign busy       = (state != IDLE);

  always_comb begin
    state_nxt     = state;
    ptr_nxt       = ptr;
    cnt_nxt       = cnt;
    settle_nxt    = settle;
    ser_dato_nxt  = ser_dato;
    grant_id_nxt  = grant_id;
    tx_byte_nxt   = tx_byte;
    err_nxt       = err;
    req_ack_nxt   = '0;
    ser_start_nxt = 1'b0;
    ser_next_nxt  = 1'b0;
    tx_start_nxt  = 1'b0;
    case (state)
      IDLE: begin
        if (arb_any) begin
          ser_dato_nxt = req_data[arb_idx*DW +: DW];
          grant_id_nxt = arb_idx;
          req_ack_nxt  = arb_grant;
          ptr_nxt      = (arb_idx == IW'(N_REQ - 1)) ? '0 : arb_idx + 1'b1;
          state_nxt    = START;
        end
      end
      START: begin
        ser_start_nxt = 1'b1;
        settle_nxt    = SETTLE_START;
        state_nxt     = SETTLE;
      end
      SETTLE: begin
        if (settle != 2'd0) settle_nxt = settle - 1'b1;
`ifdef UART_ARB_HEADER_EN
        else state_nxt = (cnt == 4'd0) ? HDR : SEND;
`else
        else state_nxt = SEND;
`endif
      end
      SEND: begin
        tx_byte_nxt  = ser_byte;
        tx_start_nxt = 1'b1;
        if (!ser_flat) err_nxt = 1'b1;
        cnt_nxt      = cnt + 1'b1;
        state_nxt    = WAIT_TX;
      end
      WAIT_TX: begin
        if (tx_done_ok) state_nxt = (cnt == BYTES_PER_WORD) ? FLUSH : NEXT;
      end
      NEXT: begin
        ser_next_nxt = 1'b1;
        settle_nxt   = SETTLE_NEXT;
        state_nxt    = SETTLE;
      end
      FLUSH: begin
        ser_next_nxt = 1'b1;
        cnt_nxt      = 4'd0;
        state_nxt    = IDLE;
      end
`ifdef UART_ARB_HEADER_EN
      HDR: begin
        tx_byte_nxt  = {HDR_TAG, 4'(grant_id)};
        tx_start_nxt = 1'b1;
        state_nxt    = HDR_WAIT;
      end
      HDR_WAIT: begin
        if (tx_done_ok) state_nxt = SEND;
      end
`endif
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state     <= IDLE;
      ptr       <= '0;
      cnt       <= 4'd0;
      settle    <= 2'd0;
      ser_dato  <= '0;
      grant_id  <= '0;
      tx_byte   <= 8'd0;
      err       <= 1'b0;
      req_ack   <= '0;
      ser_start <= 1'b0;
      ser_next  <= 1'b0;
      tx_start  <= 1'b0;
    end else begin
      state     <= state_nxt;
      ptr       <= ptr_nxt;
      cnt       <= cnt_nxt;
      settle    <= settle_nxt;
      ser_dato  <= ser_dato_nxt;
      grant_id  <= grant_id_nxt;
      tx_byte   <= tx_byte_nxt;
      err       <= err_nxt;
      req_ack   <= req_ack_nxt;
      ser_start <= ser_start_nxt;
      ser_next  <= ser_next_nxt;
      tx_start  <= tx_start_nxt;
    end
  end

endmodule

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
- Shares the 64-bit-to-byte serializer (uart_tx_4in4) among N_REQ word producers, e.g. conv/MAC result sources.
- Grants one requester at a time using round-robin and loads its word into the serializer.
- Forwards each serializer byte to the UART byte transmitter and paces the serializer with next_uart pulses driven by transmitter completion.
- Sits between the compute datapath and the UART TX PHY.

Parameters:
- N_REQ, 4, number of requesters (2..16).
- DW, 64, word width; fixed at 8 bytes per word.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous active-low reset; all state is sampled on posedge clk.
- req_valid  in  N_REQ  requester i has a word pending; held until acked.
- req_data  in  N_REQ*DW  word of requester i at bits [i*DW +: DW].
- req_ack  out  N_REQ  one-cycle pulse: word i accepted.
- ser_start  out  1  start pulse to serializer.
- ser_dato  out  DW  word to serializer.
- ser_next  out  1  next_uart pulse to serializer.
- ser_byte  in  8  serializer Output_dato.
- ser_flat  in  1  serializer flat_out.
- tx_start  out  1  one-cycle pulse: send tx_byte.
- tx_byte  out  8  byte to UART transmitter.
- tx_done  in  1  one-cycle pulse: byte fully sent.
- busy  out  1  high whenever the FSM is not in IDLE.
- grant_id  out  $clog2(N_REQ)  index of the current owner.
- err  out  1  sticky: ser_flat was low in SEND; cleared only by reset.

Behaviour:
- Reset (rst=0 at posedge): FSM=IDLE, rr pointer=0, byte count=0, word register=0.
  - All outputs 0.
  - The serializer shares rst, so no flush is needed; reset mid-word abandons the word with no ack re-issue.
- Output timing: ser_start, ser_next, tx_start and req_ack are registered pulses, exactly one cycle wide.
- IDLE:
  - If any req_valid is high, grant the lowest index at or after the rr pointer, searching cyclically.
  - In the same cycle, latch req_data[g] into ser_dato, set grant_id=g, pulse req_ack[g], and set pointer=(g+1) mod N_REQ.
  - Go to START.
  - With no requests, stay in IDLE.
- START: ser_start=1 for 1 cycle; settle counter=2; go to SETTLE.
- SETTLE: decrement the counter; at 0 go to SEND. Byte 0 is valid 3 cycles after ser_start rises; each later byte is valid 1 cycle after its ser_next.
- SEND:
  - tx_byte<=ser_byte and pulse tx_start.
  - If ser_flat=0, set err.
  - Increment count; go to WAIT_TX.
- WAIT_TX:
  - Wait for tx_done; tx_done outside WAIT_TX is ignored.
  - On tx_done with count<8, go to NEXT.
  - On tx_done with count==8, go to FLUSH.
- NEXT: ser_next=1 for 1 cycle; settle counter=1; go to SETTLE.
- FLUSH: ser_next=1 for 1 cycle, which drives the serializer's flat_out low; count=0; go to IDLE.
- Byte order is LSB first: ser_dato[7:0] first, ser_dato[63:56] last.
- Arbitration is non-preemptive: requests arriving mid-word wait. req_valid dropping before ack is legal; the request is simply not granted.
- Throughput: at most one word per (8 tx periods + per-byte overhead); back-to-back grants to different requesters are legal.
- tx_done arriving in the same cycle as tx_start is not possible by contract; it is ignored if it occurs.

Optional Feature:
- Macro: UART_ARB_HEADER_EN.
- Defined:
  - After START/SETTLE and before byte 0, insert HDR and HDR_WAIT states.
  - HDR sends header byte {4'hA, grant_id zero-extended to 4 bits} via tx_start; HDR_WAIT waits for tx_done, then goes to SEND for data byte 0.
  - The header does not touch ser_next or the byte count.
  - Each word costs 9 bytes on the link.
- Undefined: no header; 8 bytes per word.

Decomposition:
- Package uart_arb_pkg holds:
  - state_t enum: IDLE, START, SETTLE, SEND, WAIT_TX, NEXT, FLUSH, HDR, HDR_WAIT.
  - BYTES_PER_WORD=8, SETTLE_START=2, SETTLE_NEXT=1, HDR_TAG=4'hA.
- Sub-module rr_arbiter(N): inputs req, pointer; outputs one-hot grant and index; purely combinational.

Test Plan:
- Single word: req_valid=4'b0001, req_data[0]=64'h0807060504030201, tx_done 5 cycles after each tx_start.
  - Response: req_ack[0] one pulse, then tx_byte sequence 01,02,…,08.
  - Exactly 8 tx_start pulses; FLUSH pulse seen; ser_flat=0 afterwards; busy falls; err=0.
- Round-robin: req_valid=4'b1011 all held.
  - Response: grant order 0,1,3,0 with one word completed between each grant.
  - Pointer skips 2.
- Late arrival: raise req 2 while word 0 is at byte 4.
  - Response: no preemption; req 2 is granted on the first IDLE cycle after FLUSH.
- Reset mid-word: rst=0 for 1 cycle after byte 3 is sent.
  - Response: next cycle all outputs 0, busy=0, pointer=0.
  - Re-request of word 0 restarts from byte 01.
- Stalled link: hold tx_done low for 200 cycles at byte 5.
  - Response: FSM stays in WAIT_TX, no ser_next, tx_byte stable at 05.
- Header (UART_ARB_HEADER_EN defined): requester 3, word 64'h0.
  - Response: tx_byte sequence A3,00×8; 9 tx_start pulses; without the macro, 8 pulses.
